// File: rtl/uart_frame_parser_if.sv
// rtl/uart_frame_parser_if.sv - byte-in / frame-out bus of the UART command-frame parser
interface uart_frame_parser_if #(
    parameter int PAYLOAD_LEN = 11,
    parameter int CH_NUM      = 4
);
    logic                     rx_valid;
    logic [7:0]               rx_data;
    logic                     frame_valid;
    logic [7:0]               frame_func;
    logic [8*PAYLOAD_LEN-1:0] frame_payload;
    logic [CH_NUM-1:0]        ch_wr;
    logic                     frame_err;
    logic                     timeout_err;
    logic [15:0]              good_cnt;
    logic [15:0]              err_cnt;
    logic                     busy;

    // Byte source and register-bank side
    modport master (
        output rx_valid, rx_data,
        input  frame_valid, frame_func, frame_payload, ch_wr,
        input  frame_err, timeout_err, good_cnt, err_cnt, busy
    );

    // Parser side
    modport slave (
        input  rx_valid, rx_data,
        output frame_valid, frame_func, frame_payload, ch_wr,
        output frame_err, timeout_err, good_cnt, err_cnt, busy
    );
endinterface

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - HEAD/payload/checksum/TAIL frame decoder with timeout and counters
module uart_frame_parser #(
    parameter int          PAYLOAD_LEN = 11,
    parameter int          CH_NUM      = 4,
    parameter logic [7:0]  HEAD_BYTE   = 8'h55,
    parameter logic [7:0]  TAIL_BYTE   = 8'hAA,
    parameter int          TIMEOUT_CYC = 50000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    uart_frame_parser_if.slave   bus
);
    localparam int IW = $clog2(PAYLOAD_LEN);
    localparam int TW = $clog2(TIMEOUT_CYC);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PAYLOAD = 2'd1;
    localparam logic [1:0] CSUM    = 2'd2;
    localparam logic [1:0] TAIL    = 2'd3;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [7:0]    sum;
    logic          csum_ok;
    logic          ch_ok;
    logic [TW-1:0] timer;
    logic [7:0]    shadow [PAYLOAD_LEN];
    logic          expire;
    logic          good_tail;

    // A byte arriving on the expiry cycle takes priority over the timeout
    assign expire    = (state != IDLE) && !bus.rx_valid && (timer == TW'(TIMEOUT_CYC - 1));
    assign good_tail = (bus.rx_data == TAIL_BYTE) && csum_ok && ch_ok;
    assign bus.busy  = (state != IDLE);

    // Frame FSM, shadow buffer, running checksum and inter-byte timer
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= IDLE;
            idx     <= '0;
            sum     <= '0;
            csum_ok <= 1'b0;
            ch_ok   <= 1'b0;
            timer   <= '0;
            for (int i = 0; i < PAYLOAD_LEN; i++) shadow[i] <= '0;
        end else begin
            if (bus.rx_valid || state == IDLE) timer <= '0;
            else                               timer <= timer + 1'b1;

            if (expire) begin
                state <= IDLE;
            end else if (bus.rx_valid) begin
                case (state)
                    IDLE: begin
                        if (bus.rx_data == HEAD_BYTE) begin
                            state <= PAYLOAD;
                            idx   <= '0;
                            sum   <= '0;
                        end
                    end
                    PAYLOAD: begin
                        shadow[idx] <= bus.rx_data;
                        sum         <= sum + bus.rx_data;
                        idx         <= idx + 1'b1;
                        if (idx == IW'(PAYLOAD_LEN - 1)) state <= CSUM;
                    end
                    CSUM: begin
                        csum_ok <= (bus.rx_data == sum);
                        ch_ok   <= (shadow[1] != 8'd0) && (shadow[1] <= 8'(CH_NUM));
                        state   <= TAIL;
                    end
                    default: begin
                        // Tail byte is never reconsidered as a new HEAD
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Result publication: pulses, held frame contents and event counters
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bus.frame_valid   <= 1'b0;
            bus.frame_err     <= 1'b0;
            bus.timeout_err   <= 1'b0;
            bus.ch_wr         <= '0;
            bus.frame_func    <= '0;
            bus.frame_payload <= '0;
            bus.good_cnt      <= '0;
            bus.err_cnt       <= '0;
        end else begin
            bus.frame_valid <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.ch_wr       <= '0;
            if (expire) begin
                bus.timeout_err <= 1'b1;
                bus.err_cnt     <= bus.err_cnt + 16'd1;
            end else if (bus.rx_valid && state == TAIL) begin
                if (good_tail) begin
                    bus.frame_valid <= 1'b1;
                    bus.frame_func  <= shadow[0];
                    for (int i = 0; i < PAYLOAD_LEN; i++)
                        bus.frame_payload[8*(PAYLOAD_LEN-i)-1 -: 8] <= shadow[i];
                    for (int c = 0; c < CH_NUM; c++)
                        bus.ch_wr[c] <= (shadow[1] == 8'(c + 1));
                    bus.good_cnt <= bus.good_cnt + 16'd1;
                end else begin
                    bus.frame_err <= 1'b1;
                    bus.err_cnt   <= bus.err_cnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - directed self-checking bench for uart_frame_parser
module tb_uart_frame_parser;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ferr_n   = 0;
    int   terr_n   = 0;
    int   both_n   = 0;
    int   early;
    int   ferr_snap;
    int   terr_snap;

    localparam logic [87:0] P1  = 88'h01010103004400000000FF;
    localparam logic [87:0] P2  = 88'h010201FF073000FFFFFFFF;
    localparam logic [87:0] P12 = 88'h01120103004400000000FF;
    localparam logic [87:0] P04 = 88'h01040103004400000000FF;
    localparam logic [87:0] P05 = 88'h01050103004400000000FF;
    localparam logic [87:0] P00 = 88'h01000103004400000000FF;

    uart_frame_parser_if #(.PAYLOAD_LEN(11), .CH_NUM(4)) bus ();

    uart_frame_parser #(
        .PAYLOAD_LEN(11), .CH_NUM(4), .HEAD_BYTE(8'h55), .TAIL_BYTE(8'hAA), .TIMEOUT_CYC(100)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus(bus)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (bus.frame_err) ferr_n++;
        if (bus.timeout_err) terr_n++;
        if (bus.frame_err && bus.timeout_err) both_n++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pb(input logic [87:0] p, input int i);
        return p[8*(11-i)-1 -: 8];
    endfunction

    // Called and returns at a negedge; the byte is consumed at the posedge in between
    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge sys_clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [87:0] p, input logic [7:0] cs, input logic [7:0] tl);
        send_byte(8'h55);
        for (int i = 0; i < 11; i++) send_byte(pb(p, i));
        send_byte(cs);
        send_byte(tl);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        check("reset_fv", bus.frame_valid, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_good", bus.good_cnt, 0);
        check("reset_err", bus.err_cnt, 0);
        check("reset_payload", bus.frame_payload, 0);
        check("reset_chwr", bus.ch_wr, 0);

        send_frame(P1, 8'h49, 8'hAA);
        check("f1_fv", bus.frame_valid, 1);
        check("f1_chwr", bus.ch_wr, 4'b0001);
        check("f1_payload", bus.frame_payload, P1);
        check("f1_func", bus.frame_func, 8'h01);
        check("f1_good", bus.good_cnt, 1);
        check("f1_ferr", bus.frame_err, 0);
        @(negedge sys_clk);
        check("f1_fv_pulse", bus.frame_valid, 0);
        check("f1_chwr_pulse", bus.ch_wr, 0);
        check("f1_busy", bus.busy, 0);

        send_frame(P2, 8'h36, 8'hAA);
        check("f2_chwr", bus.ch_wr, 4'b0010);
        check("f2_good", bus.good_cnt, 2);

        send_frame(P2, 8'h1C, 8'hAA);
        check("badcs_ferr", bus.frame_err, 1);
        check("badcs_fv", bus.frame_valid, 0);
        check("badcs_err", bus.err_cnt, 1);
        check("badcs_payload", bus.frame_payload, P2);
        check("badcs_good", bus.good_cnt, 2);
        @(negedge sys_clk);
        check("badcs_pulse", bus.frame_err, 0);

        send_frame(P1, 8'h49, 8'hAA);
        check("after_bad_good", bus.good_cnt, 3);
        check("after_bad_payload", bus.frame_payload, P1);
        // HEAD of the next frame lands in the frame_valid cycle
        send_frame(P2, 8'h36, 8'hAA);
        check("b2b_fv", bus.frame_valid, 1);
        check("b2b_good", bus.good_cnt, 4);
        check("b2b_chwr", bus.ch_wr, 4'b0010);

        send_frame(P12, 8'h5A, 8'hAA);
        check("ch12_ferr", bus.frame_err, 1);
        check("ch12_err", bus.err_cnt, 2);
        check("ch12_payload", bus.frame_payload, P2);
        send_frame(P04, 8'h4C, 8'hAA);
        check("ch4_chwr", bus.ch_wr, 4'b1000);
        check("ch4_good", bus.good_cnt, 5);
        send_frame(P05, 8'h4D, 8'hAA);
        check("ch5_ferr", bus.frame_err, 1);
        check("ch5_err", bus.err_cnt, 3);
        send_frame(P00, 8'h48, 8'hAA);
        check("ch0_ferr", bus.frame_err, 1);
        check("ch0_err", bus.err_cnt, 4);
        @(negedge sys_clk);

        ferr_snap = ferr_n;
        send_byte(8'h13);
        send_byte(8'h27);
        @(negedge sys_clk);
        check("garbage_busy", bus.busy, 0);
        check("garbage_noerr", ferr_n, ferr_snap);
        send_frame(P1, 8'h49, 8'hAA);
        check("garbage_good", bus.good_cnt, 6);
        check("garbage_err", bus.err_cnt, 4);

        send_frame(P1, 8'h49, 8'h55);
        check("badtail_ferr", bus.frame_err, 1);
        check("badtail_err", bus.err_cnt, 5);
        check("badtail_busy", bus.busy, 0);
        send_frame(P1, 8'h49, 8'hAA);
        check("badtail_next_good", bus.good_cnt, 7);

        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h02);
        early = 0;
        for (int j = 1; j < 100; j++) begin
            @(negedge sys_clk);
            if (bus.timeout_err) early++;
        end
        check("to_early", early, 0);
        check("to_busy_before", bus.busy, 1);
        @(negedge sys_clk);
        check("to_pulse", bus.timeout_err, 1);
        check("to_busy", bus.busy, 0);
        check("to_err", bus.err_cnt, 6);
        @(negedge sys_clk);
        check("to_pulse_end", bus.timeout_err, 0);
        send_frame(P1, 8'h49, 8'hAA);
        check("to_next_good", bus.good_cnt, 7 + 1);

        terr_snap = terr_n;
        send_byte(8'h55);
        send_byte(pb(P1, 0));
        repeat (99) @(negedge sys_clk);
        for (int i = 1; i < 11; i++) send_byte(pb(P1, i));
        send_byte(8'h49);
        send_byte(8'hAA);
        check("expiry_byte_fv", bus.frame_valid, 1);
        check("expiry_byte_good", bus.good_cnt, 9);
        check("expiry_byte_noto", terr_n, terr_snap);
        check("expiry_byte_err", bus.err_cnt, 6);
        check("ferr_total", ferr_n, 5);
        check("err_overlap", both_n, 0);

        send_byte(8'h55);
        for (int i = 0; i < 5; i++) send_byte(pb(P1, i));
        ferr_snap = ferr_n;
        terr_snap = terr_n;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("rst_busy", bus.busy, 0);
        check("rst_good", bus.good_cnt, 0);
        check("rst_err", bus.err_cnt, 0);
        check("rst_payload", bus.frame_payload, 0);
        check("rst_func", bus.frame_func, 0);
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_no_ferr", ferr_n, ferr_snap);
        check("rst_no_terr", terr_n, terr_snap);
        send_frame(P1, 8'h49, 8'hAA);
        check("rst_next_fv", bus.frame_valid, 1);
        check("rst_next_good", bus.good_cnt, 1);
        check("rst_next_payload", bus.frame_payload, P1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Parametrised receive-side command-frame decoder for the DDS sample design.
- Sits between the UART byte receiver and the PWM/DDS register bank.
- Frame on the wire: HEAD byte, PAYLOAD_LEN payload bytes (byte0 = function code, byte1 = channel, rest = channel data), one checksum byte, TAIL byte.
- Validates each frame (checksum, channel range, tail, inter-byte timeout), publishes good frames with a one-hot per-channel write strobe, and counts good and bad frames.

Parameters:
- PAYLOAD_LEN, 11: payload bytes between HEAD and checksum; legal range 2..32.
- CH_NUM, 4: number of addressable channels; legal range 1..16.
- HEAD_BYTE, 8'h55: frame start marker.
- TAIL_BYTE, 8'hAA: frame end marker.
- TIMEOUT_CYC, 50000: idle sys_clk cycles allowed between bytes inside a frame; minimum 2.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous reset, active-high.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- frame_valid  out  1  one-cycle pulse: a good frame has been published.
- frame_func  out  8  payload byte0 of the last good frame.
- frame_payload  out  8*PAYLOAD_LEN  full payload of the last good frame; byte0 in the MSBs.
- ch_wr  out  CH_NUM  one-hot write strobe, coincident with frame_valid.
- frame_err  out  1  one-cycle pulse: bad checksum, bad tail, or channel out of range.
- timeout_err  out  1  one-cycle pulse: inter-byte timeout expired.
- good_cnt  out  16  good-frame count; wraps at 16'hFFFF to 0.
- err_cnt  out  16  count of frame_err plus timeout_err events; wraps at 16'hFFFF to 0.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (synchronous, sys_rst=1 at a sys_clk edge):
  - All outputs go to 0; FSM goes to IDLE; shadow buffer, byte index and timer clear.
  - Reset during a frame abandons it with no error pulse.
- FSM states are IDLE, PAYLOAD, CSUM, TAIL. Bytes are consumed only on cycles where rx_valid=1.
- IDLE:
  - rx_data==HEAD_BYTE: go to PAYLOAD; byte index=0; running sum=0.
  - Any other byte is discarded silently; no error, no count.
- PAYLOAD:
  - Each byte is stored in shadow[index] and added to the running sum (8-bit, mod 256); index increments.
  - After byte PAYLOAD_LEN-1 is stored, go to CSUM.
  - A HEAD_BYTE value inside the payload is treated as data.
- CSUM:
  - Latch the checksum-match flag (received byte == running sum).
  - Latch the channel-OK flag (1 <= shadow byte1 <= CH_NUM).
  - Go to TAIL.
- TAIL:
  - Always returns to IDLE on the next byte.
  - Good frame (byte==TAIL_BYTE, checksum matched, channel OK): on the next cycle frame_valid=1, frame_func and frame_payload load from shadow, ch_wr[byte1-1]=1, good_cnt increments.
  - Any failure: on the next cycle frame_err=1, err_cnt increments, and published outputs keep their previous values.
  - A wrong tail byte is not re-examined as a HEAD.
- Latency: exactly one sys_clk from the tail byte's rx_valid cycle to frame_valid or frame_err.
- frame_func and frame_payload change only on a good frame; they hold between frames.
- Timeout:
  - The timer counts sys_clk cycles while not in IDLE and clears on every rx_valid.
  - When it reaches TIMEOUT_CYC: FSM goes to IDLE, timeout_err pulses one cycle, err_cnt increments.
  - If rx_valid arrives on the expiry cycle, the byte wins: no timeout, the byte is processed.
- frame_err and timeout_err never assert in the same cycle. At most one error per frame.
- Back-to-back frames: a HEAD byte arriving on the cycle frame_valid is high is accepted.
- frame_valid/ch_wr of frame N and the HEAD of frame N+1 are independent.

Test Plan:
- Good frame: send 55, 01 01 01 03 00 44 00 00 00 00 FF, 49, AA.
  - Expect one frame_valid pulse one cycle after AA, with ch_wr=4'b0001.
  - Expect frame_payload=88'h01010103004400000000FF, frame_func=8'h01, good_cnt=1.
- Channel 2 frame: send 55, 01 02 01 FF 07 30 00 FF FF FF FF, 36, AA.
  - Expect ch_wr=4'b0010 and good_cnt=2.
- Bad checksum: repeat the previous frame with checksum 1C.
  - Expect frame_err pulse, err_cnt=1, frame_payload unchanged.
  - Then send a good frame and expect it accepted.
- Channel range: byte1=8'h12 with a correct checksum gives frame_err.
  - byte1=00 gives frame_err.
  - Garbage bytes 13 27 before HEAD are ignored with no error.
- Timeout: TIMEOUT_CYC=100; send 55 01 02 then stall.
  - Expect timeout_err exactly 100 cycles after the last byte.
  - The next frame decodes normally.
  - A byte landing on the expiry cycle suppresses the timeout.
- Reset mid-frame: assert sys_rst after 5 payload bytes.
  - Expect all outputs 0 and busy=0.
  - Expect no error pulse, and the next full frame accepted.
